// File: rtl/wb_seq_pkg.sv
// Shared encodings for the multi-cycle control sequencer and its write-back mux.
// Holds the state codes, write-back select codes, opcode constants and the
// opcode class codes produced by instr_class_dec.
package wb_seq_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_DM  = 2'b01;
  localparam logic [1:0] WDSEL_JMP = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;

endpackage

// File: rtl/wb_seq_instr_class_dec.sv
// instr_class_dec: purely combinational opcode classifier.
// Ports:
//   opcode  in  7  instr[6:0]
//   cls     out 3  opcode class (CLS_*)
//   illegal out 1  opcode is not supported; cls is then don't-care (CLS_ALU)
module instr_class_dec
  import wb_seq_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls,
  output logic       illegal
);

  always_comb begin
    cls     = CLS_ALU;
    illegal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LUI: cls = CLS_ALU;
      OP_LOAD:            cls = CLS_LOAD;
      OP_STORE:           cls = CLS_STORE;
      OP_BRANCH:          cls = CLS_BRANCH;
      OP_JAL, OP_JALR:    cls = CLS_JUMP;
      default:            illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_seq.sv
// wb_seq: multi-cycle instruction control sequencer.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   opcode               sampled in DECODE
//   branch_taken         sampled in EXEC (only combinational input path, to pc_wr)
//   mem_ack              data-memory completion, looked at in MEM
//   ir_wr, pc_wr, mem_rd, mem_wr, rf_wr   control strobes
//   wdsel                write-back select, changes only when leaving DECODE
//   state                current state (debug)
//   illegal, timeout     sticky error flags, cleared only by rst
//
// state  | meaning
// FETCH  | load IR, advance PC
// DECODE | classify opcode, load wdsel
// EXEC   | ALU / branch resolve / jump PC update
// MEM    | data-memory access, wait for mem_ack under a watchdog
// WB     | register-file write
// TRAP   | illegal opcode or memory timeout, held until rst
module wb_seq
  import wb_seq_pkg::*;
#(
  parameter int MEM_TMO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ack,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       rf_wr,
  output logic [1:0] wdsel,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam int CW = (MEM_TMO > 1) ? $clog2(MEM_TMO) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TMO - 1);

  logic [2:0]    dec_cls;
  logic          dec_ill;
  logic [2:0]    cls_q;
  logic [CW-1:0] wait_cnt;

  instr_class_dec u_dec (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      cls_q    <= CLS_ALU;
      wdsel    <= WDSEL_ALU;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          cls_q <= dec_cls;
          if (dec_ill) begin
            illegal <= 1'b1;
            state   <= ST_TRAP;
          end else begin
            state <= ST_EXEC;
            case (dec_cls)
              CLS_ALU:  wdsel <= WDSEL_ALU;
              CLS_LOAD: wdsel <= WDSEL_DM;
              CLS_JUMP: wdsel <= WDSEL_JMP;
              default:  ;
            endcase
          end
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_LOAD, CLS_STORE: begin
              state    <= ST_MEM;
              wait_cnt <= '0;
            end
            CLS_BRANCH: state <= ST_FETCH;
            default:    state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          // A late ack on the last allowed cycle still completes the access.
          if (mem_ack) begin
            state <= (cls_q == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (wait_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= ST_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_TRAP: state <= ST_TRAP;
        default: state <= ST_TRAP;
      endcase
    end
  end

  // Strobes are decoded from state; they are held low while rst is high so
  // the FETCH strobes first appear in the cycle after rst is released.
  always_comb begin
    ir_wr  = 1'b0;
    pc_wr  = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    rf_wr  = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        ST_EXEC: pc_wr = (cls_q == CLS_JUMP) || ((cls_q == CLS_BRANCH) && branch_taken);
        ST_MEM: begin
          mem_rd = (cls_q == CLS_LOAD);
          mem_wr = (cls_q == CLS_STORE);
        end
        ST_WB:   rf_wr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
